// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS control unit FSM
//
// Sequences FETCH/DECODE/EXEC/MEM/WB for a multicycle MIPS datapath and
// drives aluop, operand selects, PC/IR/memory/regfile enables. Memory
// states (FETCH, MEMRD, MEMWR) wait on mem_ready for any number of cycles.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   op, funct             instr[31:26] / instr[5:0] from IR
//   zero                  ALU zero flag (beq)
//   mem_ready             memory completes the current access this cycle
//   aluop                 ADD=010 SUB=011 OR=001 LUI=000 SLT=111
//   alusrca, alusrcb      ALU operand selects
//   pcsrc, pc_en          PC source select and write enable
//   iord, irwrite         memory address select, IR load
//   memwrite              memory write strobe
//   regdst, memtoreg      regfile destination / data selects
//   regwrite              regfile write enable
//   instret               retired-instruction counter (CNT_W bits, wraps)
//   illegal               illegal-instruction flag
//
// Build option: define ILLEGAL_TRAP_EN to trap unknown op/funct into a
// sticky ERR state; otherwise unknown ops retire as NOPs and unknown R
// functs execute as ADD.
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       aluop,
  output logic             alusrca,
  output logic [2:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic             pc_en,
  output logic             iord,
  output logic             irwrite,
  output logic             memwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_LUI = 3'b000;
  localparam logic [2:0] ALU_SLT = 3'b111;

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR,
    ADDIEX, ORIEX, LUIEX, IWB, BRANCH, JUMP, ERR
  } state_t;
`else
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR,
    ADDIEX, ORIEX, LUIEX, IWB, BRANCH, JUMP
  } state_t;
`endif

  state_t state, state_n;
  logic   retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state <= state_n;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    state_n  = state;
    retire   = 1'b0;
    aluop    = ALU_ADD;
    alusrca  = 1'b0;
    alusrcb  = 3'b000;
    pcsrc    = 2'b00;
    pc_en    = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    illegal  = 1'b0;
    // Outputs are gated by reset so an in-flight write is dropped in the
    // reset cycle, whatever state the register still holds.
    if (reset) begin
      state_n = FETCH;
    end else begin
      case (state)
        FETCH: begin
          alusrcb = 3'b001;
          irwrite = mem_ready;
          pc_en   = mem_ready;
          if (mem_ready) state_n = DECODE;
        end
        DECODE: begin
          // Branch target computed early so BRANCH can use ALUOut.
          alusrcb = 3'b011;
          case (op)
            OP_R:         state_n = EXEC;
            OP_LW, OP_SW: state_n = MEMADR;
            OP_BEQ:       state_n = BRANCH;
            OP_ADDI:      state_n = ADDIEX;
            OP_ORI:       state_n = ORIEX;
            OP_LUI:       state_n = LUIEX;
            OP_J:         state_n = JUMP;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              state_n = ERR;
`else
              state_n = FETCH;
              retire  = 1'b1;
`endif
            end
          endcase
        end
        EXEC: begin
          alusrca = 1'b1;
          state_n = ALUWB;
          case (funct)
            6'b100000: aluop = ALU_ADD;
            6'b100010: aluop = ALU_SUB;
            6'b100101: aluop = ALU_OR;
            6'b101010: aluop = ALU_SLT;
            default: begin
              aluop = ALU_ADD;
`ifdef ILLEGAL_TRAP_EN
              state_n = ERR;
`endif
            end
          endcase
        end
        ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
          state_n  = FETCH;
          retire   = 1'b1;
        end
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 3'b010;
          state_n = (op == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          iord = 1'b1;
          if (mem_ready) state_n = MEMWB;
        end
        MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
          state_n  = FETCH;
          retire   = 1'b1;
        end
        MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
          if (mem_ready) begin
            state_n = FETCH;
            retire  = 1'b1;
          end
        end
        ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 3'b010;
          state_n = IWB;
        end
        ORIEX: begin
          alusrca = 1'b1;
          alusrcb = 3'b100;
          aluop   = ALU_OR;
          state_n = IWB;
        end
        LUIEX: begin
          alusrcb = 3'b100;
          aluop   = ALU_LUI;
          state_n = IWB;
        end
        IWB: begin
          regwrite = 1'b1;
          state_n  = FETCH;
          retire   = 1'b1;
        end
        BRANCH: begin
          alusrca = 1'b1;
          aluop   = ALU_SUB;
          pcsrc   = 2'b01;
          pc_en   = zero;
          state_n = FETCH;
          retire  = 1'b1;
        end
        JUMP: begin
          pcsrc   = 2'b10;
          pc_en   = 1'b1;
          state_n = FETCH;
          retire  = 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        ERR: begin
          illegal = 1'b1;
        end
`endif
        default: state_n = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - self-checking bench for mc_control_fsm
module tb_mc_control_fsm;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    op = '0;
  logic [5:0]    funct = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b1;
  logic [2:0]    aluop;
  logic          alusrca;
  logic [2:0]    alusrcb;
  logic [1:0]    pcsrc;
  logic          pc_en, iord, irwrite, memwrite, regdst, memtoreg, regwrite;
  logic [CW-1:0] instret;
  logic          illegal;
  logic [15:0]   outv;

  int tests = 0;
  int fails = 0;
  int cnt   = 0;

  mc_control_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .aluop(aluop), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .pc_en(pc_en), .iord(iord),
    .irwrite(irwrite), .memwrite(memwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .instret(instret),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign outv = {aluop, alusrca, alusrcb, pcsrc, pc_en, iord, irwrite,
                 memwrite, regdst, memtoreg, regwrite};

  function automatic logic [15:0] pk(logic [2:0] al, logic a, logic [2:0] b,
                                     logic [1:0] ps, logic pe, logic io,
                                     logic ir, logic mw, logic rd,
                                     logic mt, logic rw);
    return {al, a, b, ps, pe, io, ir, mw, rd, mt, rw};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Idle/reset output pattern: every enable low, selects 0, aluop ADD.
  logic [15:0] idle_v;
  assign idle_v = pk(3'b010, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0);

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    int          lat;
    logic [15:0] c2;
    logic [15:0] fin;
  } vec_t;

  vec_t tbl[13];

  task automatic run_entry(vec_t v, string name);
    int prev;
    prev = cnt;
    op = v.op; funct = v.fn; zero = v.z; mem_ready = 1'b1;
    for (int c = 0; c < v.lat; c++) begin
      @(negedge clk);
      if (c == 0)
        chk({name, "_fetch"}, outv, pk(3'b010, 0, 3'b001, 0, 1, 0, 1, 0, 0, 0, 0));
      if (c == 2 && v.lat > 2) chk({name, "_exec"}, outv, v.c2);
      if (c == v.lat - 1) begin
        chk({name, "_final"}, outv, v.fin);
        chk({name, "_not_yet_retired"}, instret, prev);
      end
      next_cycle();
    end
    cnt = (cnt + 1) % (1 << CW);
    chk({name, "_instret"}, instret, cnt);
  endtask

  // Reference: each instruction class is a list of phases. Phase k gives the
  // expected outputs; memory phases advance only on mem_ready; the last
  // phase retires the instruction.
  function automatic logic [2:0] r_alu(logic [5:0] f);
    case (f)
      6'h22:   return 3'b011;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  task automatic ref_step(input logic [5:0] o, input logic [5:0] f, input int k,
                          input logic mr, input logic z,
                          output logic [15:0] exp, output bit adv, output bit last);
    adv = 1; last = 0;
    exp = pk(3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    if (k == 0) begin
      exp = pk(3'b010, 0, 3'b001, 0, mr, 0, mr, 0, 0, 0, 0);
      adv = mr;
    end else if (k == 1) begin
      exp = pk(3'b010, 0, 3'b011, 0, 0, 0, 0, 0, 0, 0, 0);
      last = !(o inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h0d, 6'h0f, 6'h02});
    end else begin
      case (o)
        6'h00: if (k == 2) exp = pk(r_alu(f), 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
               else begin exp = pk(3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 1); last = 1; end
        6'h23: if (k == 2) exp = pk(3'b010, 1, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0);
               else if (k == 3) begin exp = pk(3'b010, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0, 0); adv = mr; end
               else begin exp = pk(3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1); last = 1; end
        6'h2b: if (k == 2) exp = pk(3'b010, 1, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0);
               else begin exp = pk(3'b010, 0, 3'b000, 0, 0, 1, 0, 1, 0, 0, 0); adv = mr; last = 1; end
        6'h04: begin exp = pk(3'b011, 1, 3'b000, 2'b01, z, 0, 0, 0, 0, 0, 0); last = 1; end
        6'h02: begin exp = pk(3'b010, 0, 3'b000, 2'b10, 1, 0, 0, 0, 0, 0, 0); last = 1; end
        default: begin
          if (k == 3) begin exp = pk(3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1); last = 1; end
          else if (o == 6'h08) exp = pk(3'b010, 1, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0);
          else if (o == 6'h0d) exp = pk(3'b001, 1, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0);
          else exp = pk(3'b000, 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0);
        end
      endcase
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b1;
    next_cycle();
    repeat (2) begin
      @(negedge clk);
      chk("reset_outputs", outv, idle_v);
      chk("reset_instret", instret, 0);
      chk("reset_illegal", illegal, 0);
      next_cycle();
    end
    reset = 1'b0;
    cnt = 0;
  endtask

  initial begin
    logic [5:0]  ops[9];
    logic [5:0]  fns[5];
    int          sched[9];
    logic [15:0] exp;
    bit          adv, last, done;
    int          k, prev;

    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h0d, 6'h0f, 6'h02, 6'h3f};
    fns = '{6'h20, 6'h22, 6'h25, 6'h2a, 6'h3f};
    tbl[0]  = '{6'h00, 6'h20, 0, 4, pk(3'b010, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0), pk(3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 1)};
    tbl[1]  = '{6'h00, 6'h22, 0, 4, pk(3'b011, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0), pk(3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 1)};
    tbl[2]  = '{6'h00, 6'h25, 0, 4, pk(3'b001, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0), pk(3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 1)};
    tbl[3]  = '{6'h00, 6'h2a, 0, 4, pk(3'b111, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0), pk(3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 1)};
    tbl[4]  = '{6'h23, 6'h00, 0, 5, pk(3'b010, 1, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0), pk(3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1)};
    tbl[5]  = '{6'h2b, 6'h00, 0, 4, pk(3'b010, 1, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0), pk(3'b010, 0, 3'b000, 0, 0, 1, 0, 1, 0, 0, 0)};
    tbl[6]  = '{6'h04, 6'h00, 1, 3, pk(3'b011, 1, 3'b000, 2'b01, 1, 0, 0, 0, 0, 0, 0), pk(3'b011, 1, 3'b000, 2'b01, 1, 0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{6'h04, 6'h00, 0, 3, pk(3'b011, 1, 3'b000, 2'b01, 0, 0, 0, 0, 0, 0, 0), pk(3'b011, 1, 3'b000, 2'b01, 0, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{6'h08, 6'h00, 0, 4, pk(3'b010, 1, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0), pk(3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[9]  = '{6'h0d, 6'h00, 0, 4, pk(3'b001, 1, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0), pk(3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[10] = '{6'h0f, 6'h00, 0, 4, pk(3'b000, 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0), pk(3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[11] = '{6'h02, 6'h00, 0, 3, pk(3'b010, 0, 3'b000, 2'b10, 1, 0, 0, 0, 0, 0, 0), pk(3'b010, 0, 3'b000, 2'b10, 1, 0, 0, 0, 0, 0, 0)};
    tbl[12] = '{6'h00, 6'h3f, 0, 4, pk(3'b010, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0), pk(3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 1)};

    do_reset();
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 12; i++) run_entry(tbl[i], $sformatf("tbl%0d", i));
`else
    for (int i = 0; i < 13; i++) run_entry(tbl[i], $sformatf("tbl%0d", i));
`endif

    // lw with two stall cycles in FETCH and two in MEMRD: 9 cycles total.
    sched = '{0, 0, 1, 1, 1, 0, 0, 1, 1};
    op = 6'h23; funct = '0; prev = cnt;
    for (int c = 0; c < 9; c++) begin
      mem_ready = sched[c][0];
      @(negedge clk);
      if (c == 0) chk("lw_fetch_stall", outv, pk(3'b010, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0));
      if (c == 5) chk("lw_memrd_stall", outv, pk(3'b010, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0, 0));
      if (c == 8) begin
        chk("lw_memwb", outv, pk(3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1));
        chk("lw_not_yet_retired", instret, prev);
      end
      next_cycle();
    end
    cnt = (cnt + 1) % (1 << CW);
    chk("lw_stall_instret", instret, cnt);
    mem_ready = 1'b1;

    // Unknown opcode.
    op = 6'h3f;
`ifdef ILLEGAL_TRAP_EN
    prev = cnt;
    next_cycle();
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("err_illegal", illegal, 1);
      chk("err_outputs", outv, idle_v);
      chk("err_instret", instret, prev);
      next_cycle();
    end
`else
    run_entry('{6'h3f, 6'h00, 0, 2, 16'h0, pk(3'b010, 0, 3'b011, 0, 0, 0, 0, 0, 0, 0, 0)}, "nop_op");
    chk("nop_illegal", illegal, 0);
`endif

    // Randomised instruction stream with random memory waits; 4-bit counter wraps.
    do_reset();
    for (int n = 0; n < 60; n++) begin
`ifdef ILLEGAL_TRAP_EN
      op = ops[$urandom_range(0, 7)];
      funct = fns[$urandom_range(0, 3)];
`else
      op = ops[$urandom_range(0, 8)];
      funct = fns[$urandom_range(0, 4)];
`endif
      k = 0; done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
        mem_ready = ($urandom_range(0, 3) != 0);
        zero = 1'($urandom);
        @(negedge clk);
        ref_step(op, funct, k, mem_ready, zero, exp, adv, last);
        chk($sformatf("rand%0d_op%h_k%0d", n, op, k), outv, exp);
        next_cycle();
        if (adv) begin
          if (last) done = 1;
          else k++;
        end
      end
      chk("rand_timeout", done, 1);
      if (done) cnt = (cnt + 1) % (1 << CW);
      chk("rand_instret", instret, cnt);
    end

    // Reset during a stalled MEMWR abandons the store.
    op = 6'h2b; mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("memwr_active", outv, pk(3'b010, 0, 3'b000, 0, 0, 1, 0, 1, 0, 0, 0));
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("memwr_reset_outputs", outv, idle_v);
    next_cycle();
    reset = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("after_reset_fetch", outv, pk(3'b010, 0, 3'b001, 0, 1, 0, 1, 0, 0, 0, 0));
    chk("after_reset_instret", instret, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
